ama_error_monitor: RTL

AMA_ERROR_MONITOR -- requirements
Module: ama_error_monitor

---
 rtl/ama_error_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ama_error_monitor.sv
// ama_error_monitor
// Measures the accuracy of an approximate adder over a run of exactly
// 2^CNT_W samples. Each accepted sample carries the adder operands and the
// approximate adder's {Cout, SUM}. A two-stage pipeline first forms the exact
// sum, then the error distance |exact - approx|. The run statistics are
// sample count, error count, maximum error distance and summed error distance.
module ama_error_monitor #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    input  logic [WIDTH-1:0]       appr_sum,
    input  logic                   appr_cout,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W:0]         sample_count,
    output logic [CNT_W:0]         err_count,
    output logic [WIDTH:0]         max_ed,
    output logic [WIDTH+CNT_W:0]   sum_ed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Count value held just before the final accept of a run (2^CNT_W - 1).
    localparam logic [CNT_W:0] LAST_COUNT = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] ONE_COUNT  = {{CNT_W{1'b0}}, 1'b1};

    state_t               state;

    logic                 run_start;
    logic                 accept;
    logic                 last_accept;

    logic [WIDTH:0]       exact_sum;
    logic [WIDTH:0]       ed_next;

    logic                 s1_valid;
    logic [WIDTH:0]       s1_exact;
    logic [WIDTH:0]       s1_approx;

    logic                 s2_valid;
    logic [WIDTH:0]       s2_ed;

    // A start is only meaningful while idle or after a completed run.
    assign run_start   = start && ((state == IDLE) || (state == DONE));
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_count == LAST_COUNT);

    // Exact reference sum, zero-extended so the carry-out lands in the top bit.
    assign exact_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Unsigned distance between exact and approximate results.
    assign ed_next = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                             : (s1_approx - s1_exact);

    // Run control FSM; the handshake and status flags are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_accept) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Once stage 1 is empty the last sample sits in stage 2 and
                    // retires into the statistics on this same edge.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Samples accepted in the current run, counted on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
        end else if (run_start) begin
            sample_count <= '0;
        end else if (accept) begin
            sample_count <= sample_count + ONE_COUNT;
        end
    end

    // Stage 1 captures the exact sum and the approximate result of an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid <= accept && !run_start;
            if (accept) begin
                s1_exact  <= exact_sum;
                s1_approx <= {appr_cout, appr_sum};
            end
        end
    end

    // Stage 2 holds the error distance of the sample that was in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else if (run_start) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_next;
            end
        end
    end

    // Statistics accumulate each error distance leaving stage 2; sum_ed is wide enough never to overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (run_start) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (s2_valid) begin
            sum_ed <= sum_ed + {{CNT_W{1'b0}}, s2_ed};
            if (s2_ed > max_ed) begin
                max_ed <= s2_ed;
            end
            if (s2_ed != '0) begin
                err_count <= err_count + ONE_COUNT;
            end
        end
    end

endmodule
